// File: rtl/mul_seq_pkg.sv
// Shared types for the RV64M multiply sequencing controller.
package mul_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Signedness class of an op; ops in the same class produce the same full product.
  typedef enum logic [1:0] {
    CLS_SS   = 2'd0,
    CLS_SU   = 2'd1,
    CLS_UU   = 2'd2,
    CLS_NONE = 2'd3
  } mul_cls_e;

  function automatic mul_cls_e op_class(input logic [OP_W-1:0] op);
    mul_cls_e cls;
    case (op)
      MUL, MULH: cls = CLS_SS;
      MULHSU:    cls = CLS_SU;
      MULHU:     cls = CLS_UU;
      default:   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Sign correction and result selection for the unsigned array product.
module mul_sign_fix
  import mul_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] prod,
  input  logic              neg,
  input  logic [OP_W-1:0]   op,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] corr_prod;

  // Negate the full product when needed, then pick the half the op asks for.
  always_comb begin
    corr_prod = neg ? -prod : prod;
    result    = '0;
    case (op)
      MUL:                 result = corr_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: result = corr_prod[2*XLEN-1:XLEN];
      MULW:                result = {{(XLEN-32){corr_prod[31]}}, corr_prod[31:0]};
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the shared XLEN x XLEN multicycle multiplier array.
// Optional feature: define MUL_SEQ_FUSE_EN to keep the last full product and
// answer a repeated MUL/MULH/MULHSU/MULHU on the same operands without CALC.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic [2*XLEN-1:0] mul_p,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  mul_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   mul_a_q, mul_a_d;
  logic [XLEN-1:0]   mul_b_q, mul_b_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              neg_q, neg_d;

  logic [XLEN-1:0]   opnd_a, opnd_b, mag_a, mag_b;
  logic              sign_a, sign_b, neg_in;

  logic [2*XLEN-1:0] fix_prod;
  logic              fix_neg;
  logic [OP_W-1:0]   fix_op;
  logic [XLEN-1:0]   fix_result;

`ifdef MUL_SEQ_FUSE_EN
  logic              keep_valid_q, keep_valid_d;
  logic [2*XLEN-1:0] keep_p_q, keep_p_d;
  logic [XLEN-1:0]   keep_rs1_q, keep_rs1_d;
  logic [XLEN-1:0]   keep_rs2_q, keep_rs2_d;
  mul_cls_e          keep_cls_q, keep_cls_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  mul_cls_e          req_cls;
  logic              fuse_hit;
`endif

  // Pick operand views and signedness per op, then form magnitudes and the negate flag.
  always_comb begin
    opnd_a = req_rs1;
    opnd_b = req_rs2;
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (req_op)
      MUL, MULH: begin
        sign_a = req_rs1[XLEN-1];
        sign_b = req_rs2[XLEN-1];
      end
      MULHSU: sign_a = req_rs1[XLEN-1];
      MULW: begin
        opnd_a = {{(XLEN-32){req_rs1[31]}}, req_rs1[31:0]};
        opnd_b = {{(XLEN-32){req_rs2[31]}}, req_rs2[31:0]};
        sign_a = req_rs1[31];
        sign_b = req_rs2[31];
      end
      default: ;
    endcase
    mag_a  = sign_a ? -opnd_a : opnd_a;
    mag_b  = sign_b ? -opnd_b : opnd_b;
    neg_in = (sign_a ^ sign_b) && (opnd_a != '0) && (opnd_b != '0);
  end

`ifdef MUL_SEQ_FUSE_EN
  // A repeat of the kept operands in the same signedness class can reuse the kept product.
  always_comb begin
    req_cls  = op_class(req_op);
    fuse_hit = keep_valid_q && (req_cls != CLS_NONE) && (req_cls == keep_cls_q) &&
               (req_rs1 == keep_rs1_q) && (req_rs2 == keep_rs2_q);
  end
`endif

  // Feed the correction unit from the live array, or from the kept product on a fused hit.
  always_comb begin
    fix_prod = mul_p;
    fix_neg  = neg_q;
    fix_op   = op_q;
`ifdef MUL_SEQ_FUSE_EN
    if (state_q == IDLE) begin
      fix_prod = keep_p_q;
      fix_neg  = 1'b0;
      fix_op   = req_op;
    end
`endif
  end

  mul_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .prod   (fix_prod),
    .neg    (fix_neg),
    .op     (fix_op),
    .result (fix_result)
  );

  // Next-state logic: accept in IDLE, hold the array through CALC, present the result in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    neg_d       = neg_q;
    resp_data_d = resp_data_q;
`ifdef MUL_SEQ_FUSE_EN
    keep_valid_d = keep_valid_q;
    keep_p_d     = keep_p_q;
    keep_rs1_d   = keep_rs1_q;
    keep_rs2_d   = keep_rs2_q;
    keep_cls_d   = keep_cls_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
`endif
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (!flush && req_valid) begin
          op_d  = req_op;
          tag_d = req_tag;
`ifdef MUL_SEQ_FUSE_EN
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          if (req_op == MULW) keep_valid_d = 1'b0;
          if (fuse_hit) begin
            resp_data_d = fix_result;
            state_d     = DONE;
          end else begin
            mul_a_d = mag_a;
            mul_b_d = mag_b;
            neg_d   = neg_in;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
`else
          mul_a_d = mag_a;
          mul_b_d = mag_b;
          neg_d   = neg_in;
          cnt_d   = CNT_INIT;
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          resp_data_d = fix_result;
          state_d     = DONE;
`ifdef MUL_SEQ_FUSE_EN
          keep_cls_d   = op_class(op_q);
          keep_valid_d = (op_class(op_q) != CLS_NONE);
          keep_p_d     = neg_q ? -mul_p : mul_p;
          keep_rs1_d   = rs1_q;
          keep_rs2_d   = rs2_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef MUL_SEQ_FUSE_EN
    if (flush) keep_valid_d = 1'b0;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      neg_q       <= 1'b0;
      resp_data_q <= '0;
`ifdef MUL_SEQ_FUSE_EN
      keep_valid_q <= 1'b0;
      keep_p_q     <= '0;
      keep_rs1_q   <= '0;
      keep_rs2_q   <= '0;
      keep_cls_q   <= CLS_NONE;
      rs1_q        <= '0;
      rs2_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      neg_q       <= neg_d;
      resp_data_q <= resp_data_d;
`ifdef MUL_SEQ_FUSE_EN
      keep_valid_q <= keep_valid_d;
      keep_p_q     <= keep_p_d;
      keep_rs1_q   <= keep_rs1_d;
      keep_rs2_q   <= keep_rs2_d;
      keep_cls_q   <= keep_cls_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
`endif
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign resp_data = resp_data_q;
  assign resp_tag  = tag_q;

endmodule
